// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage RV32I pipeline.
// Define HAZARD_PERF_EN to build the stall/branch-flush performance counters.
module hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_D,
    input  logic [ADDR_W-1:0] rs2_D,
    input  logic [ADDR_W-1:0] rs1_E,
    input  logic [ADDR_W-1:0] rs2_E,
    input  logic [ADDR_W-1:0] rd_E,
    input  logic [ADDR_W-1:0] rd_M,
    input  logic [ADDR_W-1:0] rd_W,
    input  logic              load_E,
    input  logic              reg_write_M,
    input  logic              reg_write_W,
    input  logic              pc_src_E,
    input  logic              mem_req_M,
    input  logic              mem_ready,
    output logic              stall_F,
    output logic              stall_D,
    output logic              stall_E,
    output logic              stall_M,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_W,
    output logic [1:0]        forward_A_E,
    output logic [1:0]        forward_B_E,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);

    typedef enum logic {RUN, MISS} state_t;

    state_t state;
    logic   miss_active;
    logic   branch_flush;
    logic   load_use;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (mem_req_M && !mem_ready) state <= MISS;
                MISS:    if (mem_ready) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // The first miss cycle stalls combinationally; in MISS only mem_ready matters.
    always_comb begin
        miss_active  = !rst && (((state == RUN) && mem_req_M && !mem_ready) ||
                                ((state == MISS) && !mem_ready));
        branch_flush = !rst && !miss_active && pc_src_E;
        load_use     = !rst && !miss_active && !pc_src_E && load_E &&
                       (rd_E != '0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
    end

    assign stall_F = miss_active || load_use;
    assign stall_D = miss_active || load_use;
    assign stall_E = miss_active;
    assign stall_M = miss_active;
    assign flush_D = branch_flush;
    assign flush_E = branch_flush || load_use;
    assign flush_W = miss_active;

    // M result is younger than W, so it wins when both write the same register.
    always_comb begin
        forward_A_E = 2'b00;
        if (reg_write_M && (rd_M != '0) && (rd_M == rs1_E))
            forward_A_E = 2'b10;
        else if (reg_write_W && (rd_W != '0) && (rd_W == rs1_E))
            forward_A_E = 2'b01;

        forward_B_E = 2'b00;
        if (reg_write_M && (rd_M != '0) && (rd_M == rs2_E))
            forward_B_E = 2'b10;
        else if (reg_write_W && (rd_W != '0) && (rd_W == rs2_E))
            forward_B_E = 2'b01;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_F)
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            if (branch_flush)
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized checks of hazard_unit against a behavioural model.
// Counters are built narrow so the wrap case is reachable in a short run.
module tb_hazard_unit;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [ADDR_W-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic              load_E, reg_write_M, reg_write_W, pc_src_E, mem_req_M, mem_ready;
    logic              stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0]        forward_A_E, forward_B_E;
    logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;
    logic [6:0]        ctrl;

    assign ctrl = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W};

    hazard_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .load_E(load_E), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .pc_src_E(pc_src_E), .mem_req_M(mem_req_M), .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    int          checks = 0;
    int          passes = 0;
    bit          m_outstanding;
    int unsigned m_stalls, m_flushes;
    bit          pend_stall, pend_flush, pend_wait;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int unsigned expCnt(input int unsigned n);
`ifdef HAZARD_PERF_EN
        return n % (32'd1 << CNT_W);
`else
        return n * 0;
`endif
    endfunction

    function automatic logic [1:0] refFwd(input logic [ADDR_W-1:0] src);
        if (src == 0) return 2'd0;
        if (reg_write_M && rd_M == src) return 2'd2;
        if (reg_write_W && rd_W == src) return 2'd1;
        return 2'd0;
    endfunction

    task automatic applyStimulus(input bit ld, input bit br, input bit req, input bit rdy,
                                 input bit rwm, input bit rww);
        load_E = ld; pc_src_E = br; mem_req_M = req; mem_ready = rdy;
        reg_write_M = rwm; reg_write_W = rww;
    endtask

    task automatic setRegs(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                           input logic [ADDR_W-1:0] c, input logic [ADDR_W-1:0] d,
                           input logic [ADDR_W-1:0] e, input logic [ADDR_W-1:0] m,
                           input logic [ADDR_W-1:0] w);
        rs1_D = a; rs2_D = b; rs1_E = c; rs2_E = d; rd_E = e; rd_M = m; rd_W = w;
    endtask

    // Called one unit after a rising edge; compares at the falling edge.
    task automatic sample();
        bit          waiting, br, lu;
        logic [6:0]  e;
        #4;
        waiting = !rst && !mem_ready && (m_outstanding || mem_req_M);
        br = !rst && !waiting && pc_src_E;
        lu = !rst && !waiting && !br && load_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
        e  = {waiting | lu, waiting | lu, waiting, waiting, br, br | lu, waiting};
        checkOutput("ctrl", ctrl, e);
        checkOutput("fwdA", forward_A_E, refFwd(rs1_E));
        checkOutput("fwdB", forward_B_E, refFwd(rs2_E));
        checkOutput("stallcnt", perf_stall_cnt, rst ? 0 : expCnt(m_stalls));
        checkOutput("flushcnt", perf_flush_cnt, rst ? 0 : expCnt(m_flushes));
        pend_stall = e[6];
        pend_flush = br;
        pend_wait  = waiting;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_outstanding = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls      += pend_stall;
            m_flushes     += pend_flush;
            m_outstanding  = pend_wait;
        end
        #1;
    endtask

    task automatic resetCycle();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0);
        sample();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        m_outstanding = 0; m_stalls = 0; m_flushes = 0;
        rst = 1'b1;
        setRegs(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;

        // Reset dominates a miss request and a branch.
        applyStimulus(0, 1, 1, 0, 0, 0);
        sample();
        checkOutput("rst_ctrl", ctrl, 7'b0000000);
        checkOutput("rst_cnt", perf_stall_cnt, 0);
        advance();
        rst = 1'b0;

        setRegs(1, 5, 0, 0, 5, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        sample(); checkOutput("lu_ctrl", ctrl, 7'b1100010); advance();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sample(); checkOutput("lu_after", ctrl, 7'b0000000); advance();
        setRegs(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        sample(); checkOutput("lu_x0", ctrl, 7'b0000000); advance();

        setRegs(1, 5, 0, 0, 5, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0);
        sample(); checkOutput("br_lu", ctrl, 7'b0000110); advance();
        applyStimulus(0, 0, 0, 1, 0, 0);
        sample(); checkOutput("br_cnt", perf_flush_cnt, expCnt(1)); advance();

        resetCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            sample(); checkOutput("miss_ctrl", ctrl, 7'b1111001); advance();
        end
        applyStimulus(0, 0, 1, 1, 0, 0);
        sample();
        checkOutput("miss_done", ctrl, 7'b0000000);
        checkOutput("miss_cnt", perf_stall_cnt, expCnt(3));
        advance();

        setRegs(0, 0, 7, 0, 0, 7, 7);
        applyStimulus(0, 0, 0, 1, 1, 1);
        sample(); checkOutput("fwd_m", forward_A_E, 2'b10); advance();
        applyStimulus(0, 0, 0, 1, 0, 1);
        sample(); checkOutput("fwd_w", forward_A_E, 2'b01); advance();
        setRegs(0, 0, 0, 0, 0, 7, 7);
        sample(); checkOutput("fwd_x0", forward_A_E, 2'b00); advance();

        // Asynchronous reset during the second wait cycle of a miss.
        applyStimulus(0, 0, 1, 0, 0, 0);
        sample(); advance();
        rst = 1'b1;
        sample();
        checkOutput("rstmiss_ctrl", ctrl, 7'b0000000);
        checkOutput("rstmiss_cnt", perf_stall_cnt, 0);
        advance();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        sample(); checkOutput("rstmiss_run", ctrl, 7'b0000000); advance();

        resetCycle();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 0);
            sample(); advance();
        end
        applyStimulus(0, 0, 0, 1, 0, 0);
        sample(); checkOutput("wrap_cnt", perf_stall_cnt, expCnt(17)); advance();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            setRegs($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7));
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                          $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
            sample();
            advance();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
